// File: rtl/load_data_reg.sv
// load_data_reg: formats a memory read into a load result register.
//
// A load request is checked for a legal type and natural alignment in IDLE.
// An accepted load waits in WAIT for MRD_VALID, or gives up after TIMEOUT
// cycles. The selected byte, halfword or word is then extracted,
// sign- or zero-extended, and registered into DR.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ld_req     start a load (sampled only in IDLE)
//   ld_type    000 LB, 001 LH, 010 LW, 011 FULL, 100 LBU, 101 LHU, 110 LWU, 111 illegal
//   addr_lo    byte offset of the load address
//   mrd        memory read data
//   mrd_valid  mrd is valid this cycle
//   flush      abort the current load and return to IDLE
//   dr         formatted load data
//   dr_valid   dr holds the result of the most recent completed load
//   busy       high exactly while in WAIT (registered)
//   err        00 none, 01 misaligned, 10 timeout, 11 illegal type (sticky)
module load_data_reg #(
  parameter int WIDTH   = 32,  // 32 or 64
  parameter int TIMEOUT = 15   // 1..255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ld_req,
  input  logic [2:0]                   ld_type,
  input  logic [$clog2(WIDTH/8)-1:0]   addr_lo,
  input  logic [WIDTH-1:0]             mrd,
  input  logic                         mrd_valid,
  input  logic                         flush,
  output logic [WIDTH-1:0]             dr,
  output logic                         dr_valid,
  output logic                         busy,
  output logic [1:0]                   err
);
  localparam int OFFW = $clog2(WIDTH/8);

  localparam logic [2:0] T_LB  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LW  = 3'b010;
  localparam logic [2:0] T_FUL = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_LHU = 3'b101;
  localparam logic [2:0] T_LWU = 3'b110;
  localparam logic [2:0] T_ILL = 3'b111;

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_MIS  = 2'b01;
  localparam logic [1:0] E_TMO  = 2'b10;
  localparam logic [1:0] E_ILL  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        typ_q, typ_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  dr_q, dr_d;
  logic              dr_valid_q, dr_valid_d;
  logic              busy_q, busy_d;
  logic [1:0]        err_q, err_d;

  logic              misaligned;
  logic [WIDTH-1:0]  sh;
  logic [WIDTH-1:0]  fmt;

  // Natural alignment of the requested access size.
  always_comb begin
    misaligned = 1'b0;
    case (ld_type)
      T_LH, T_LHU: misaligned = addr_lo[0];
      T_LW, T_LWU: misaligned = |addr_lo[1:0];
      T_FUL:       misaligned = |addr_lo;
      default:     misaligned = 1'b0;
    endcase
  end

  // The latched offset is already aligned to the access size, so shifting
  // by offset*8 lands the selected byte/half/word in the LSBs for every type.
  always_comb begin
    sh  = mrd >> {off_q, 3'b000};
    fmt = sh;
    case (typ_q)
      T_LB:  begin fmt = {WIDTH{sh[7]}};  fmt[7:0]  = sh[7:0];  end
      T_LH:  begin fmt = {WIDTH{sh[15]}}; fmt[15:0] = sh[15:0]; end
      T_LW:  begin fmt = {WIDTH{sh[31]}}; fmt[31:0] = sh[31:0]; end
      T_LBU: begin fmt = '0;              fmt[7:0]  = sh[7:0];  end
      T_LHU: begin fmt = '0;              fmt[15:0] = sh[15:0]; end
      T_LWU: begin fmt = '0;              fmt[31:0] = sh[31:0]; end
      default: fmt = sh;  // FULL: offset is 0, data passes through
    endcase
  end

  always_comb begin
    state_d    = state_q;
    typ_d      = typ_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    dr_d       = dr_q;
    dr_valid_d = dr_valid_q;
    busy_d     = busy_q;
    err_d      = err_q;
    if (flush) begin
      // Highest priority; DR and ERR are deliberately left alone.
      state_d    = IDLE;
      dr_valid_d = 1'b0;
      busy_d     = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_req) begin
            dr_valid_d = 1'b0;
            if (ld_type == T_ILL) begin
              err_d = E_ILL;
            end else if (misaligned) begin
              err_d = E_MIS;
            end else begin
              typ_d   = ld_type;
              off_d   = addr_lo;
              err_d   = E_NONE;
              cnt_d   = '0;
              busy_d  = 1'b1;
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (mrd_valid) begin
            // Data on the final allowed cycle still completes normally.
            dr_d       = fmt;
            dr_valid_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'(TIMEOUT - 1)) begin
              err_d   = E_TMO;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;  // DONE lasts one cycle
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      typ_q      <= T_LB;
      off_q      <= '0;
      cnt_q      <= '0;
      dr_q       <= '0;
      dr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= E_NONE;
    end else begin
      state_q    <= state_d;
      typ_q      <= typ_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      dr_q       <= dr_d;
      dr_valid_q <= dr_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign dr       = dr_q;
  assign dr_valid = dr_valid_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_load_data_reg.sv
module tb_load_data_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_req32 = 1'b0, ld_req64 = 1'b0;
  logic [2:0]  ld_type = 3'b000;
  logic [1:0]  a32 = '0;
  logic [2:0]  a64 = '0;
  logic [31:0] m32 = '0;
  logic [63:0] m64 = '0;
  logic        mrd_valid = 1'b0, flush = 1'b0;

  logic [31:0] dr32;  logic dv32, busy32; logic [1:0] err32;
  logic [63:0] dr64;  logic dv64, busy64; logic [1:0] err64;

  always #5 clk = ~clk;

  load_data_reg #(.WIDTH(32), .TIMEOUT(3)) u32 (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req32), .ld_type(ld_type), .addr_lo(a32),
    .mrd(m32), .mrd_valid(mrd_valid), .flush(flush),
    .dr(dr32), .dr_valid(dv32), .busy(busy32), .err(err32));

  load_data_reg #(.WIDTH(64), .TIMEOUT(3)) u64 (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req64), .ld_type(ld_type), .addr_lo(a64),
    .mrd(m64), .mrd_valid(mrd_valid), .flush(flush),
    .dr(dr64), .dr_valid(dv64), .busy(busy64), .err(err64));

  int nchk = 0, nerr = 0;
  bit sel = 1'b0;                 // 0: 32-bit DUT, 1: 64-bit DUT
  logic [63:0] last32 = '0, last64 = '0;

  function automatic logic [63:0] o_dr();   return sel ? dr64 : {32'b0, dr32}; endfunction
  function automatic logic        o_dv();   return sel ? dv64 : dv32;          endfunction
  function automatic logic        o_busy(); return sel ? busy64 : busy32;      endfunction
  function automatic logic [1:0]  o_err();  return sel ? err64 : err32;        endfunction
  function automatic logic [63:0] o_last(); return sel ? last64 : last32;      endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Presents a request for one cycle; returns at the negedge after the accepting edge.
  task automatic drive_req(input bit s, input logic [2:0] t, input logic [2:0] a);
    sel = s;
    @(negedge clk);
    ld_type = t; a32 = a[1:0]; a64 = a;
    ld_req32 = !s; ld_req64 = s;
    @(negedge clk);
    ld_req32 = 1'b0; ld_req64 = 1'b0;
  endtask

  // Accepted load with MRD_VALID in the gap-th WAIT cycle.
  task automatic do_load(input string nm, input bit s, input logic [2:0] t, input logic [2:0] a,
                         input logic [63:0] mrd, input int gap, input logic [63:0] exp);
    drive_req(s, t, a);
    chk({nm, " busy"}, {63'b0, o_busy()}, 64'd1);
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      chk({nm, " busy hold"}, {63'b0, o_busy()}, 64'd1);
    end
    m32 = mrd[31:0]; m64 = mrd; mrd_valid = 1'b1;
    @(negedge clk);
    mrd_valid = 1'b0;
    chk({nm, " dr"},   o_dr(), exp);
    chk({nm, " dv"},   {63'b0, o_dv()}, 64'd1);
    chk({nm, " busy0"}, {63'b0, o_busy()}, 64'd0);
    chk({nm, " err"},  {62'b0, o_err()}, 64'd0);
    if (s) last64 = exp; else last32 = exp;
  endtask

  // Rejected request: error set, DR untouched, no WAIT entry, error sticky.
  task automatic do_bad(input string nm, input bit s, input logic [2:0] t, input logic [2:0] a,
                        input logic [1:0] e);
    drive_req(s, t, a);
    chk({nm, " err"},  {62'b0, o_err()}, {62'b0, e});
    chk({nm, " dv"},   {63'b0, o_dv()}, 64'd0);
    chk({nm, " busy"}, {63'b0, o_busy()}, 64'd0);
    chk({nm, " dr"},   o_dr(), o_last());
    @(negedge clk);
    chk({nm, " sticky"}, {62'b0, o_err()}, {62'b0, e});
  endtask

  typedef struct {
    string       nm;
    bit          w64;
    logic [2:0]  t;
    logic [2:0]  a;
    logic [63:0] mrd;
    int          gap;
    logic [63:0] exp;
    logic [1:0]  err;
  } vec_t;

  vec_t tv[$];

  initial begin
    tv.push_back('{"lb32 a3",   1'b0, 3'b000, 3'd3, 64'h0000_0000_80FF_1234, 2, 64'h0000_0000_FFFF_FF80, 2'b00});
    tv.push_back('{"lhu32 a2",  1'b0, 3'b101, 3'd2, 64'h0000_0000_8001_0000, 1, 64'h0000_0000_0000_8001, 2'b00});
    tv.push_back('{"lh32 a2",   1'b0, 3'b001, 3'd2, 64'h0000_0000_8001_0000, 1, 64'h0000_0000_FFFF_8001, 2'b00});
    tv.push_back('{"lbu32 a1",  1'b0, 3'b100, 3'd1, 64'h0000_0000_80FF_1234, 1, 64'h0000_0000_0000_0012, 2'b00});
    tv.push_back('{"lb32 a2",   1'b0, 3'b000, 3'd2, 64'h0000_0000_80FF_1234, 1, 64'h0000_0000_FFFF_FFFF, 2'b00});
    tv.push_back('{"lw32",      1'b0, 3'b010, 3'd0, 64'h0000_0000_8765_4321, 1, 64'h0000_0000_8765_4321, 2'b00});
    tv.push_back('{"lwu32",     1'b0, 3'b110, 3'd0, 64'h0000_0000_8765_4321, 1, 64'h0000_0000_8765_4321, 2'b00});
    tv.push_back('{"full32",    1'b0, 3'b011, 3'd0, 64'h0000_0000_8765_4321, 1, 64'h0000_0000_8765_4321, 2'b00});
    tv.push_back('{"lh32 a0",   1'b0, 3'b001, 3'd0, 64'h0000_0000_1234_F00D, 1, 64'h0000_0000_FFFF_F00D, 2'b00});
    tv.push_back('{"lw64 a4",   1'b1, 3'b010, 3'd4, 64'h9000_0000_0000_0001, 1, 64'hFFFF_FFFF_9000_0000, 2'b00});
    tv.push_back('{"lwu64 a4",  1'b1, 3'b110, 3'd4, 64'h9000_0000_0000_0001, 1, 64'h0000_0000_9000_0000, 2'b00});
    tv.push_back('{"lw64 a0",   1'b1, 3'b010, 3'd0, 64'h9000_0000_0000_0001, 1, 64'h0000_0000_0000_0001, 2'b00});
    tv.push_back('{"full64",    1'b1, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 1, 64'h0123_4567_89AB_CDEF, 2'b00});
    tv.push_back('{"lhu64 a6",  1'b1, 3'b101, 3'd6, 64'h0123_4567_89AB_CDEF, 1, 64'h0000_0000_0000_0123, 2'b00});
    tv.push_back('{"lb64 a7",   1'b1, 3'b000, 3'd7, 64'hF012_3456_789A_BCDE, 1, 64'hFFFF_FFFF_FFFF_FFF0, 2'b00});
    tv.push_back('{"lbu64 a5",  1'b1, 3'b100, 3'd5, 64'h0123_4567_89AB_CDEF, 1, 64'h0000_0000_0000_0045, 2'b00});
    tv.push_back('{"lh32 a1",   1'b0, 3'b001, 3'd1, 64'h0, 1, 64'h0, 2'b01});
    tv.push_back('{"ill32 a1",  1'b0, 3'b111, 3'd1, 64'h0, 1, 64'h0, 2'b11});
    tv.push_back('{"lw32 a2",   1'b0, 3'b010, 3'd2, 64'h0, 1, 64'h0, 2'b01});
    tv.push_back('{"full64 a4", 1'b1, 3'b011, 3'd4, 64'h0, 1, 64'h0, 2'b01});
    tv.push_back('{"lwu64 a2",  1'b1, 3'b110, 3'd2, 64'h0, 1, 64'h0, 2'b01});
    tv.push_back('{"ill64 a0",  1'b1, 3'b111, 3'd0, 64'h0, 1, 64'h0, 2'b11});

    // Reset state (asynchronous, no clock edge needed)
    #12;
    chk("rst dr32",  {32'b0, dr32}, 64'd0);
    chk("rst dr64",  dr64, 64'd0);
    chk("rst flags32", {60'b0, dv32, busy32, err32}, 64'd0);
    chk("rst flags64", {60'b0, dv64, busy64, err64}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tv[i]) begin
      if (tv[i].err == 2'b00)
        do_load(tv[i].nm, tv[i].w64, tv[i].t, tv[i].a, tv[i].mrd, tv[i].gap, tv[i].exp);
      else
        do_bad(tv[i].nm, tv[i].w64, tv[i].t, tv[i].a, tv[i].err);
    end

    // Timeout after 3 WAIT cycles with no data
    drive_req(1'b0, 3'b010, 3'd0);
    chk("tmo busy1", {63'b0, busy32}, 64'd1);
    @(negedge clk); chk("tmo busy2", {63'b0, busy32}, 64'd1);
    @(negedge clk); chk("tmo busy3", {63'b0, busy32}, 64'd1);
    @(negedge clk);
    chk("tmo busy0", {63'b0, busy32}, 64'd0);
    chk("tmo err",   {62'b0, err32}, 64'd2);
    chk("tmo dv",    {63'b0, dv32}, 64'd0);
    chk("tmo dr",    {32'b0, dr32}, last32);
    // Stray data in IDLE is ignored
    m32 = 32'hDEAD_BEEF; mrd_valid = 1'b1;
    @(negedge clk); mrd_valid = 1'b0;
    chk("idle mrd dr", {32'b0, dr32}, last32);
    chk("idle mrd dv", {63'b0, dv32}, 64'd0);

    // Data on the 3rd WAIT cycle completes normally
    do_load("late lwu32", 1'b0, 3'b110, 3'd0, 64'h0000_0000_CAFE_F00D, 3, 64'h0000_0000_CAFE_F00D);

    // LD_REQ during DONE is ignored
    ld_type = 3'b010; a32 = 2'd0; ld_req32 = 1'b1;
    @(negedge clk); ld_req32 = 1'b0;
    chk("done req busy", {63'b0, busy32}, 64'd0);
    chk("done req dv",   {63'b0, dv32}, 64'd1);
    @(negedge clk);
    chk("done req idle", {63'b0, busy32}, 64'd0);

    // FLUSH beats MRD_VALID in WAIT
    drive_req(1'b0, 3'b100, 3'd1);
    flush = 1'b1; mrd_valid = 1'b1; m32 = 32'hFFFF_FFFF;
    @(negedge clk); flush = 1'b0; mrd_valid = 1'b0;
    chk("flush busy", {63'b0, busy32}, 64'd0);
    chk("flush dv",   {63'b0, dv32}, 64'd0);
    chk("flush dr",   {32'b0, dr32}, last32);
    chk("flush err",  {62'b0, err32}, 64'd0);

    // FLUSH beats LD_REQ in IDLE and keeps a sticky error
    do_bad("mis pre", 1'b0, 3'b001, 3'd1, 2'b01);
    ld_type = 3'b010; a32 = 2'd0; ld_req32 = 1'b1; flush = 1'b1;
    @(negedge clk); ld_req32 = 1'b0; flush = 1'b0;
    chk("flush req busy", {63'b0, busy32}, 64'd0);
    chk("flush req err",  {62'b0, err32}, 64'd1);

    // Reset pulse mid-WAIT
    drive_req(1'b0, 3'b010, 3'd0);
    chk("wait before rst", {63'b0, busy32}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dr",    {32'b0, dr32}, 64'd0);
    chk("async rst flags", {60'b0, dv32, busy32, err32}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    m32 = 32'h1234_5678; mrd_valid = 1'b1;
    @(negedge clk); mrd_valid = 1'b0;
    chk("post rst dr",    {32'b0, dr32}, 64'd0);
    chk("post rst flags", {60'b0, dv32, busy32, err32}, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
